// File: rtl/ifstmt_stim_pkg.sv
// ifstmt_stim_pkg
// Shared types, constants and helper functions for the if-statement
// stimulus driver: FSM state encoding, LFSR taps/seed, LFSR step and
// signature fold.
package ifstmt_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'h5A;

    // Galois right-shift LFSR step
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        logic [7:0] nxt;
        if (cur[0]) begin
            nxt = (cur >> 1) ^ LFSR_TAPS;
        end else begin
            nxt = cur >> 1;
        end
        return nxt;
    endfunction

    // One compaction step: rotate left by one, then fold in both terms
    function automatic logic [15:0] sig_fold(input logic [15:0] sig,
                                             input logic [15:0] c_term,
                                             input logic [15:0] r_term);
        return {sig[14:0], sig[15]} ^ c_term ^ r_term;
    endfunction

endpackage

// File: rtl/ifstmt_stim_driver_lfsr8.sv
// lfsr8
// 8-bit LFSR holding the stimulus data sequence. Reset loads SEED (an
// all-zero seed would lock up, so it becomes 8'h01); advance steps it.
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   advance  step the sequence at this edge
//   value    current LFSR state
module lfsr8
    import ifstmt_stim_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    output logic [7:0] value
);

    localparam logic [7:0] RESET_VALUE = (SEED == 8'h00) ? 8'h01 : SEED;

    // LFSR state register; only reset reloads the seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= RESET_VALUE;
        end else if (advance) begin
            value <= lfsr_next(value);
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/ifstmt_stim_driver.sv
// ifstmt_stim_driver
// Plays NUM_VECTORS stimulus vectors (sel = index, data_in = LFSR) into the
// if-statement block on a start request and compacts its responses into a
// 16-bit signature.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       run request (only honoured in IDLE)
//   sel, data_in                stimulus outputs
//   dut_data_out, dut_branch_flag  registered responses of the block
//   dut_comb_preview            combinational response of the block
//   busy, done                  run in progress / one-cycle completion pulse
//   vec_count                   vectors issued in current or last run
//   signature                   compacted response
module ifstmt_stim_driver
    import ifstmt_stim_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 16,
    parameter logic [7:0]  SEED        = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  sel,
    output logic [7:0]  data_in,
    input  logic [7:0]  dut_data_out,
    input  logic        dut_branch_flag,
    input  logic [7:0]  dut_comb_preview,
    output logic        busy,
    output logic        done,
    output logic [7:0]  vec_count,
    output logic [15:0] signature
);

    localparam logic [7:0] LAST_COUNT = NUM_VECTORS[7:0];

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  lfsr_s;
    logic        adv_s;
    logic        last_s;
    logic [3:0]  sel_s;
    logic [7:0]  data_s;
    logic [7:0]  cnt_s;
    logic        busy_s;
    logic        done_s;
    logic        comb_en_s;
    logic        resp_en_r;
    logic [15:0] c_term_s;
    logic [15:0] r_term_s;
    logic [15:0] sig_s;

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (adv_s),
        .value   (lfsr_s)
    );

    // All vectors issued once the count reaches the run length
    assign last_s = (vec_count == LAST_COUNT);

    // A vector is on the outputs during every DRIVE cycle
    assign comb_en_s = (state_r == DRIVE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = DRIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                if (last_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = DRIVE;
                end
            end
            DRAIN:   state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and the LFSR advance request
    always_comb begin
        sel_s  = 4'h0;
        data_s = 8'h00;
        cnt_s  = vec_count;
        busy_s = 1'b0;
        done_s = 1'b0;
        adv_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    data_s = lfsr_s;
                    cnt_s  = 8'd1;
                    busy_s = 1'b1;
                    adv_s  = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            DRIVE: begin
                busy_s = 1'b1;
                if (last_s) begin
                    sel_s  = 4'h0;
                    data_s = 8'h00;
                end else begin
                    // vec_count is the index of the vector issued now; sel wraps mod 16
                    sel_s  = vec_count[3:0];
                    data_s = lfsr_s;
                    cnt_s  = vec_count + 8'd1;
                    adv_s  = 1'b1;
                end
            end
            DRAIN: begin
                done_s = 1'b1;
            end
            DONE: begin
                done_s = 1'b0;
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
    end

    // Next signature: cleared at start, folded whenever either capture is active
    always_comb begin
        c_term_s = comb_en_s ? {8'h00, dut_comb_preview} : 16'h0000;
        r_term_s = resp_en_r ? {dut_data_out, 7'b0000000, dut_branch_flag} : 16'h0000;
        if ((state_r == IDLE) && start) begin
            sig_s = 16'h0000;
        end else if (comb_en_s || resp_en_r) begin
            sig_s = sig_fold(signature, c_term_s, r_term_s);
        end else begin
            sig_s = signature;
        end
    end

    // Output registers; resp_en trails comb_en by one cycle to catch the
    // registered response of the vector presented in the previous cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel       <= 4'h0;
            data_in   <= 8'h00;
            vec_count <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            signature <= 16'h0000;
            resp_en_r <= 1'b0;
        end else begin
            sel       <= sel_s;
            data_in   <= data_s;
            vec_count <= cnt_s;
            busy      <= busy_s;
            done      <= done_s;
            signature <= sig_s;
            resp_en_r <= comb_en_s;
        end
    end

endmodule

// File: tb/tb_ifstmt_stim_driver.sv
`timescale 1ns/1ps
module tb_ifstmt_stim_driver;

    localparam int NI = 4;

    function automatic int nv_of(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            default: return 16;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a   [NI];
    logic        start_a [NI];
    logic [7:0]  cmb_a   [NI];
    logic [7:0]  dout_a  [NI];
    logic        flag_a  [NI];
    logic [3:0]  sel_a   [NI];
    logic [7:0]  din_a   [NI];
    logic        busy_a  [NI];
    logic        done_a  [NI];
    logic [7:0]  cnt_a   [NI];
    logic [15:0] sig_a   [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        ifstmt_stim_driver #(
            .NUM_VECTORS (nv_of(gi)),
            .SEED        (8'h5A)
        ) u_dut (
            .clk              (clk),
            .rst_n            (rst_a[gi]),
            .start            (start_a[gi]),
            .sel              (sel_a[gi]),
            .data_in          (din_a[gi]),
            .dut_data_out     (dout_a[gi]),
            .dut_branch_flag  (flag_a[gi]),
            .dut_comb_preview (cmb_a[gi]),
            .busy             (busy_a[gi]),
            .done             (done_a[gi]),
            .vec_count        (cnt_a[gi]),
            .signature        (sig_a[gi])
        );
    end

    int total;
    int bad;
    logic [7:0] mlfsr [NI];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mstep(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    task automatic chk_reset(input int g, input string tag);
        chk($sformatf("%s sel g%0d", tag, g),  32'(sel_a[g]),  32'h0);
        chk($sformatf("%s din g%0d", tag, g),  32'(din_a[g]),  32'h0);
        chk($sformatf("%s busy g%0d", tag, g), 32'(busy_a[g]), 32'h0);
        chk($sformatf("%s done g%0d", tag, g), 32'(done_a[g]), 32'h0);
        chk($sformatf("%s cnt g%0d", tag, g),  32'(cnt_a[g]),  32'h0);
        chk($sformatf("%s sig g%0d", tag, g),  32'(sig_a[g]),  32'h0);
    endtask

    // Entered and left just after a rising edge with instance g in IDLE.
    // rnd=0 ties the responses to kc/kd/kf, rnd=1 randomizes them per cycle.
    task automatic do_run(input int g, input bit rnd, input logic [7:0] kc,
                          input logic [7:0] kd, input logic kf, input bit tog,
                          input int abort_at, output logic [7:0] d0, output logic [7:0] d1);
        int n;
        logic [7:0]  cq [$];
        logic [7:0]  dq [$];
        logic        fq [$];
        logic [15:0] msig;
        logic [3:0]  e_sel;
        logic [7:0]  e_din;
        logic [7:0]  e_cnt;
        logic        e_busy;
        logic        e_done;
        n  = nv_of(g);
        d0 = 8'h00;
        d1 = 8'h00;
        start_a[g] = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= n + 2; c++) begin
            start_a[g] = tog ? 1'($urandom_range(0, 1)) : 1'b0;
            cmb_a[g]  = rnd ? 8'($urandom) : kc;
            dout_a[g] = rnd ? 8'($urandom) : kd;
            flag_a[g] = rnd ? 1'($urandom_range(0, 1)) : kf;
            cq.push_back(cmb_a[g]);
            dq.push_back(dout_a[g]);
            fq.push_back(flag_a[g]);
            @(negedge clk);
            if (c <= n) begin
                e_sel = 4'((c - 1) % 16); e_din = mlfsr[g]; mlfsr[g] = mstep(mlfsr[g]);
                e_cnt = 8'(c); e_busy = 1'b1; e_done = 1'b0;
            end else if (c == n + 1) begin
                e_sel = 4'h0; e_din = 8'h00; e_cnt = 8'(n); e_busy = 1'b1; e_done = 1'b0;
            end else begin
                e_sel = 4'h0; e_din = 8'h00; e_cnt = 8'(n); e_busy = 1'b0; e_done = 1'b1;
            end
            if (c == 1) begin
                d0 = din_a[g];
                chk($sformatf("sig clear g%0d", g), 32'(sig_a[g]), 32'h0);
            end
            if (c == 2) d1 = din_a[g];
            chk($sformatf("sel g%0d c%0d", g, c),  32'(sel_a[g]),  32'(e_sel));
            chk($sformatf("din g%0d c%0d", g, c),  32'(din_a[g]),  32'(e_din));
            chk($sformatf("cnt g%0d c%0d", g, c),  32'(cnt_a[g]),  32'(e_cnt));
            chk($sformatf("busy g%0d c%0d", g, c), 32'(busy_a[g]), 32'(e_busy));
            chk($sformatf("done g%0d c%0d", g, c), 32'(done_a[g]), 32'(e_done));
            if (c == abort_at) begin
                rst_a[g] = 1'b0;
                #1;
                chk_reset(g, "abort");
                mlfsr[g] = 8'h5A;
                start_a[g] = 1'b0;
                @(posedge clk); #1;
                rst_a[g] = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        start_a[g] = 1'b0;
        // Cycle c captures the preview while a vector is shown (c<=n) and the
        // registered response to the previous vector (c>=2)
        msig = 16'h0000;
        for (int c = 1; c <= n + 1; c++) begin
            msig = {msig[14:0], msig[15]};
            if (c <= n) msig = msig ^ {8'h00, cq[c - 1]};
            if (c >= 2) msig = msig ^ {dq[c - 1], 7'b0000000, fq[c - 1]};
        end
        @(negedge clk);
        chk($sformatf("idle sig g%0d", g),  32'(sig_a[g]),  32'(msig));
        chk($sformatf("idle cnt g%0d", g),  32'(cnt_a[g]),  32'(n));
        chk($sformatf("idle done g%0d", g), 32'(done_a[g]), 32'h0);
        chk($sformatf("idle busy g%0d", g), 32'(busy_a[g]), 32'h0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          g;
        logic [7:0]  comb;
        logic [7:0]  dout;
        logic        flag;
        logic [7:0]  exp_d0;
        logic [15:0] exp_sig;
    } vec_t;

    vec_t tab [4];

    initial begin
        logic [7:0] d0;
        logic [7:0] d1;
        total = 0;
        bad   = 0;
        tab[0] = '{g: 0, comb: 8'h01, dout: 8'h00, flag: 1'b0, exp_d0: 8'h5A, exp_sig: 16'h0002};
        tab[1] = '{g: 0, comb: 8'h01, dout: 8'h80, flag: 1'b1, exp_d0: 8'h2D, exp_sig: 16'h8003};
        tab[2] = '{g: 2, comb: 8'h01, dout: 8'h00, flag: 1'b0, exp_d0: 8'h5A, exp_sig: 16'h000E};
        tab[3] = '{g: 1, comb: 8'h00, dout: 8'hFF, flag: 1'b1, exp_d0: 8'h5A, exp_sig: 16'h0102};
        for (int g = 0; g < NI; g++) begin
            rst_a[g] = 1'b0; start_a[g] = 1'b0;
            cmb_a[g] = 8'h00; dout_a[g] = 8'h00; flag_a[g] = 1'b0;
            mlfsr[g] = 8'h5A;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) chk_reset(g, "reset");
        @(posedge clk); #1;
        for (int g = 0; g < NI; g++) rst_a[g] = 1'b1;
        @(posedge clk); #1;

        // Tied-response runs with hand-computed signatures
        for (int i = 0; i < 4; i++) begin
            do_run(tab[i].g, 1'b0, tab[i].comb, tab[i].dout, tab[i].flag, 1'b0, 0, d0, d1);
            chk($sformatf("tab%0d d0", i),  32'(d0), 32'(tab[i].exp_d0));
            chk($sformatf("tab%0d sig", i), 32'(sig_a[tab[i].g]), 32'(tab[i].exp_sig));
        end

        // Back-to-back on the 2-vector instance continues the LFSR sequence
        do_run(1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 0, d0, d1);
        chk("b2b d0", 32'(d0), 32'h0000_00AE);
        chk("b2b d1", 32'(d1), 32'h0000_0057);

        // Reset during cycle 2 of a 16-vector run, then restart from the seed
        do_run(3, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 2, d0, d1);
        do_run(3, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 0, d0, d1);
        chk("post-abort d0", 32'(d0), 32'h0000_005A);
        chk("post-abort d1", 32'(d1), 32'h0000_002D);

        // Random responses with start toggling through DRIVE, DRAIN and DONE
        for (int r = 0; r < 3; r++) begin
            for (int g = 0; g < NI; g++) begin
                do_run(g, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 0, d0, d1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
